// File: rtl/axioma_uart_tx_arbiter.sv
// axioma_uart_tx_arbiter: configures one axioma_uart (baud, 8N1, TXEN) after reset,
// then shares its transmitter between NUM_REQ byte producers, round-robin per byte.
// Each byte: poll UCSR0A.UDRE, then write UDR0 and pulse the requester's ready.
// Build macro AXIOMA_UART_ARB_LOCK_EN: hold the grant across a packet until req_last.
module axioma_uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter logic [15:0] BAUD_DIV    = 16'h0067,
   parameter logic [7:0]  UCSR0C_INIT = 8'h06,
   parameter int unsigned IDW         = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [5:0]           io_addr,
   output logic [7:0]           io_wdata,
   input  logic [7:0]           io_rdata,
   output logic                 io_read,
   output logic                 io_write,
   output logic                 init_done,
   output logic                 busy,
   output logic [IDW-1:0]       grant_id
);
   localparam int unsigned    CW       = IDW + 1;
   localparam int unsigned    UDRE_BIT = 5;
   localparam logic [5:0]     A_UCSR0A = 6'h00;
   localparam logic [5:0]     A_UCSR0B = 6'h01;
   localparam logic [5:0]     A_UCSR0C = 6'h02;
   localparam logic [5:0]     A_UBRR0L = 6'h04;
   localparam logic [5:0]     A_UBRR0H = 6'h05;
   localparam logic [5:0]     A_UDR0   = 6'h06;
   localparam logic [7:0]     UCSR0B_V = 8'h08;
   localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      ST_CFG_H, ST_CFG_L, ST_CFG_C, ST_CFG_B, ST_IDLE, ST_POLL, ST_WRITE
   } state_t;

   state_t               state_q, state_d;
   logic                 start_q;
   logic [IDW-1:0]       rr_q, rr_d, gid_q, gid_d, gid_nxt, rr_sel, sel_id;
   logic [7:0]           data_q, data_d;
   logic                 found, take;
   logic [7:0]           byte_arr [NUM_REQ];
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic [5:0]           addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 read_q, read_d, write_q, write_d, done_q, done_d, busy_q, busy_d;
   logic                 unused_ok;
`ifdef AXIOMA_UART_ARB_LOCK_EN
   logic                 last_q, last_d, lock_q, lock_d;
`endif

   // Split the flat request bus into per-requester bytes
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) byte_arr[i] = req_data[8*i +: 8];
   end

   // Round-robin search starting at rr_q, wrapping at NUM_REQ
   always_comb begin
      logic [CW-1:0] idx;
      found  = 1'b0;
      rr_sel = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = CW'(rr_q) + CW'(k);
         if (idx >= CW'(NUM_REQ)) idx = idx - CW'(NUM_REQ);
         if (!found && req_valid[IDW'(idx)]) begin
            found  = 1'b1;
            rr_sel = IDW'(idx);
         end
      end
   end

`ifdef AXIOMA_UART_ARB_LOCK_EN
   // While locked only the owning requester may be granted
   always_comb begin
      if (lock_q) begin
         take   = req_valid[gid_q];
         sel_id = gid_q;
      end else begin
         take   = found;
         sel_id = rr_sel;
      end
   end
   assign unused_ok = ^{io_rdata[7:6], io_rdata[4:0]};
`else
   assign take      = found;
   assign sel_id    = rr_sel;
   assign unused_ok = ^{io_rdata[7:6], io_rdata[4:0], req_last};
`endif

   assign gid_nxt = (gid_q == LAST_ID) ? '0 : gid_q + IDW'(1);

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_CFG_H;
         start_q <= 1'b0;
         rr_q    <= '0;
         gid_q   <= '0;
         data_q  <= '0;
`ifdef AXIOMA_UART_ARB_LOCK_EN
         last_q  <= 1'b0;
         lock_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         start_q <= 1'b1;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         data_q  <= data_d;
`ifdef AXIOMA_UART_ARB_LOCK_EN
         last_q  <= last_d;
         lock_q  <= lock_d;
`endif
      end
   end

   // Next state: init sequence, grant, UDRE poll, data write
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      data_d  = data_q;
`ifdef AXIOMA_UART_ARB_LOCK_EN
      last_d  = last_q;
      lock_d  = lock_q;
`endif
      if (!start_q) begin
         state_d = ST_CFG_H;
      end else begin
         case (state_q)
            ST_CFG_H: state_d = ST_CFG_L;
            ST_CFG_L: state_d = ST_CFG_C;
            ST_CFG_C: state_d = ST_CFG_B;
            ST_CFG_B: state_d = ST_IDLE;
            ST_IDLE: begin
               if (take) begin
                  state_d = ST_POLL;
                  gid_d   = sel_id;
                  data_d  = byte_arr[sel_id];
`ifdef AXIOMA_UART_ARB_LOCK_EN
                  last_d  = req_last[sel_id];
`endif
               end
            end
            ST_POLL: if (io_rdata[UDRE_BIT]) state_d = ST_WRITE;
            ST_WRITE: begin
               state_d = ST_IDLE;
`ifdef AXIOMA_UART_ARB_LOCK_EN
               if (last_q) begin
                  lock_d = 1'b0;
                  rr_d   = gid_nxt;
               end else begin
                  lock_d = 1'b1;
               end
`else
               rr_d = gid_nxt;
`endif
            end
            default: state_d = ST_CFG_H;
         endcase
      end
   end

   // Output decode of the upcoming state, registered below
   always_comb begin
      ready_d = '0;
      addr_d  = '0;
      wdata_d = '0;
      read_d  = 1'b0;
      write_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = done_q;
      case (state_d)
         ST_CFG_H: begin write_d = 1'b1; addr_d = A_UBRR0H; wdata_d = BAUD_DIV[15:8]; end
         ST_CFG_L: begin write_d = 1'b1; addr_d = A_UBRR0L; wdata_d = BAUD_DIV[7:0];  end
         ST_CFG_C: begin write_d = 1'b1; addr_d = A_UCSR0C; wdata_d = UCSR0C_INIT;    end
         ST_CFG_B: begin write_d = 1'b1; addr_d = A_UCSR0B; wdata_d = UCSR0B_V;       end
         ST_IDLE:  done_d = 1'b1;
         ST_POLL:  begin read_d = 1'b1; addr_d = A_UCSR0A; busy_d = 1'b1; end
         ST_WRITE: begin
            write_d        = 1'b1;
            addr_d         = A_UDR0;
            wdata_d        = data_q;
            busy_d         = 1'b1;
            ready_d[gid_d] = 1'b1;
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= ready_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         read_q  <= read_d;
         write_q <= write_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign req_ready = ready_q;
   assign io_addr   = addr_q;
   assign io_wdata  = wdata_q;
   assign io_read   = read_q;
   assign io_write  = write_q;
   assign init_done = done_q;
   assign busy      = busy_q;
   assign grant_id  = gid_q;

endmodule

// File: tb/tb_axioma_uart_tx_arbiter.sv
// Directed bench for axioma_uart_tx_arbiter: init sequence, single byte, UDRE stall,
// round-robin order, reset during poll, and packet streaming (lock or per-byte).
module tb_axioma_uart_tx_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '0;
   logic [3:0]  req_ready;
   logic [5:0]  io_addr;
   logic [7:0]  io_wdata;
   logic [7:0]  io_rdata = '0;
   logic        io_read, io_write, init_done, busy;
   logic [1:0]  grant_id;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] valid;
      logic [7:0] d0;
      logic [7:0] rdata;
      logic       rd;
      logic       wr;
      logic [5:0] addr;
      logic [7:0] wdata;
      logic [3:0] rdy;
      logic       bsy;
      logic       idone;
      logic [1:0] gid;
   } vec_t;

   vec_t tab [9];

   always #5 clk = ~clk;

   axioma_uart_tx_arbiter #(
      .NUM_REQ(4), .BAUD_DIV(16'h0067), .UCSR0C_INIT(8'h06), .IDW(2)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
      .io_read(io_read), .io_write(io_write),
      .init_done(init_done), .busy(busy), .grant_id(grant_id)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({req_ready, io_read, io_write, io_addr, io_wdata, busy, init_done, grant_id});
   endfunction

   function automatic logic [63:0] exp_of(input vec_t v);
      return 64'({v.rdy, v.rd, v.wr, v.addr, v.wdata, v.bsy, v.idone, v.gid});
   endfunction

   // Advance one clock and sample just after the edge; bus-hygiene checks every cycle
   task automatic step();
      @(posedge clk);
      #1;
      chk("strobe_excl", 64'(io_read & io_write), 64'd0);
      chk("idle_bus_zero", 64'((!io_read && !io_write) ? {io_addr, io_wdata} : 14'd0), 64'd0);
   endtask

   task automatic run_vec(input int i, input string tag);
      req_valid = tab[i].valid;
      req_data  = {24'h0, tab[i].d0};
      io_rdata  = tab[i].rdata;
      step();
      chk($sformatf("%s%0d", tag, i), outs(), exp_of(tab[i]));
   endtask

   function automatic int ready_id();
      int id = -1;
      for (int b = 0; b < 4; b++) if (req_ready[b]) id = b;
      return id;
   endfunction

   initial begin
      int reads, writes, acks, cnt1, id;
      int at [6];
      int exp_rr [6];
      int exp_st [4];
      logic [7:0] exp_byte;

      //          valid  d0     rdata  rd    wr    addr   wdata  rdy   bsy   idone gid
      tab[0] = '{4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 6'h05, 8'h00, 4'h0, 1'b0, 1'b0, 2'd0};
      tab[1] = '{4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 6'h04, 8'h67, 4'h0, 1'b0, 1'b0, 2'd0};
      tab[2] = '{4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 6'h02, 8'h06, 4'h0, 1'b0, 1'b0, 2'd0};
      tab[3] = '{4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 6'h01, 8'h08, 4'h0, 1'b0, 1'b0, 2'd0};
      tab[4] = '{4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 4'h0, 1'b0, 1'b1, 2'd0};
      tab[5] = '{4'h1, 8'h55, 8'h20, 1'b1, 1'b0, 6'h00, 8'h00, 4'h0, 1'b1, 1'b1, 2'd0};
      tab[6] = '{4'h1, 8'h55, 8'h20, 1'b0, 1'b1, 6'h06, 8'h55, 4'h1, 1'b1, 1'b1, 2'd0};
      tab[7] = '{4'h0, 8'h00, 8'h20, 1'b0, 1'b0, 6'h00, 8'h00, 4'h0, 1'b0, 1'b1, 2'd0};
      tab[8] = '{4'h0, 8'h00, 8'h20, 1'b0, 1'b0, 6'h00, 8'h00, 4'h0, 1'b0, 1'b1, 2'd0};
      exp_rr = '{0, 1, 2, 3, 0, 1};
`ifdef AXIOMA_UART_ARB_LOCK_EN
      exp_st = '{1, 1, 1, 0};
`else
      exp_st = '{1, 0, 1, 1};
`endif

      // Reset state, then init sequence and a single byte from requester 0
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", outs(), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 9; i++) run_vec(i, "vec");

      // UDRE stall: 10 reads, no write, then the write of requester 3's byte
      req_valid = 4'b1000;
      req_data  = 32'hC3000000;
      io_rdata  = 8'h00;
      reads = 0;
      writes = 0;
      step();
      if (io_read) reads++;
      if (io_write) writes++;
      for (int i = 0; i < 9; i++) begin
         step();
         if (io_read) reads++;
         if (io_write) writes++;
      end
      chk("stall_reads", 64'(reads), 64'd10);
      chk("stall_writes", 64'(writes), 64'd0);
      io_rdata = 8'h20;
      step();
      chk("stall_write", outs(), 64'({4'b1000, 1'b0, 1'b1, 6'h06, 8'hC3, 1'b1, 1'b1, 2'd3}));
      req_valid = '0;
      step();

      // All four valid: round-robin 0,1,2,3,0,1, one ack per requester per 12 cycles
      req_valid = 4'hF;
      req_data  = 32'h13121110;
      acks = 0;
      at = '{0, 0, 0, 0, 0, 0};
      for (int c = 1; c <= 40 && acks < 6; c++) begin
         step();
         if (req_ready != 4'h0) begin
            chk("rr_ready", 64'(req_ready), 64'(4'b0001 << exp_rr[acks]));
            chk("rr_wdata", 64'({io_write, io_addr, io_wdata}),
                64'({1'b1, 6'h06, 8'h10 + 8'(exp_rr[acks])}));
            at[acks] = c;
            acks++;
            if (acks == 6) req_valid = '0;
         end
      end
      chk("rr_count", 64'(acks), 64'd6);
      chk("rr_req0_period", 64'(at[4] - at[0]), 64'd12);
      chk("rr_req1_period", 64'(at[5] - at[1]), 64'd12);
      step();

      // Reset while polling: immediate zero outputs, no write, init reruns
      req_valid = 4'b0100;
      req_data  = 32'h00770000;
      io_rdata  = 8'h00;
      step();
      chk("poll_before_reset", 64'({io_read, io_addr, grant_id}), 64'({1'b1, 6'h00, 2'd2}));
      #2;
      reset = 1'b1;
      #1;
      chk("reset_async_outs", outs(), 64'd0);
      req_valid = '0;
      io_rdata  = 8'h20;
      writes = 0;
      repeat (2) begin
         step();
         if (io_write) writes++;
      end
      chk("reset_no_write", 64'(writes), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) run_vec(i, "reinit");

      // Requester 1 streams three bytes; requester 0 joins after the first
      req_valid = 4'b0010;
      req_data  = 32'h0000A100;
      req_last  = 4'b0000;
      io_rdata  = 8'h20;
      acks = 0;
      cnt1 = 0;
      for (int c = 0; c < 60 && acks < 4; c++) begin
         step();
         if (req_ready != 4'h0) begin
            id = ready_id();
            chk("stream_onehot", 64'($countones(req_ready)), 64'd1);
            chk($sformatf("stream_id%0d", acks), 64'(id), 64'(exp_st[acks]));
            exp_byte = (id == 1) ? 8'hA1 + 8'(cnt1) : 8'hB0;
            chk("stream_wdata", 64'(io_wdata), 64'(exp_byte));
            acks++;
            if (id == 1) begin
               cnt1++;
               if (cnt1 == 1) begin
                  req_valid[0]  = 1'b1;
                  req_data[7:0] = 8'hB0;
               end
               if (cnt1 == 3) begin
                  req_valid[1] = 1'b0;
                  req_last[1]  = 1'b0;
               end else begin
                  req_data[15:8] = 8'hA1 + 8'(cnt1);
                  req_last[1]    = (cnt1 == 2);
               end
            end else begin
               req_valid[0] = 1'b0;
            end
         end
      end
      chk("stream_count", 64'(acks), 64'd4);
      step();
      chk("final_idle", 64'({busy, io_read, io_write, init_done}), 64'({3'b000, 1'b1}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
